flex_countdown_timer: RTL and testbench
=======================================

// Module: flex_countdown_timer
// PURPOSE
//  Loadable, parameterised down-counter with terminal-count detection: the count-down counterpart of
//  the up-counting flex counter. Captures a start value, decrements on count_enable and signals
//  expiry with a one-cycle done pulse. Serves as the bit/byte and timeout timer in the control paths.
// PARAMETERS
//  NUM_CNT_BITS  4  width of load_val / count_out; legal range 2..16
// PORTS
//  clk            in   1             system clock, rising-edge
//  rst            in   1             synchronous, active-high reset
//  clear          in   1             sync clear: count_out->0, state->IDLE
//  load           in   1             capture load_val, (re)start countdown
//  load_val       in   NUM_CNT_BITS  start value (also the auto-reload value)
//  count_enable   in   1             decrement strobe, honoured only in RUN
//  count_out      out  NUM_CNT_BITS  current count (registered)
//  terminal_flag  out  1             high while state==RUN && count_out==1 (registered)
//  done           out  1             1-cycle pulse on the 1->expiry transition (registered)
//  busy           out  1             state==RUN
//  expired        out  1             state==EXPIRED
// BEHAVIOUR
//  - Reset (rst=1 at an edge): count_out=0, reload_reg=0, state=IDLE, terminal_flag=done=busy=expired=0.
//  - Priority per edge: rst > clear > load > count_enable.
//  - clear: count_out=0, state=IDLE, flags 0, reload_reg unchanged.
//  - load (any state): reload_reg<=load_val, count_out<=load_val; load_val!=0 -> RUN; load_val==0 ->
//    EXPIRED with done=0 (no countdown happened). load mid-RUN restarts; no done pulse is generated.
//  - IDLE: count_out held; count_enable ignored.
//  - RUN, count_enable=1, count_out>1: count_out-1. count_enable=0: hold (discontinuous counting OK).
//  - RUN, count_enable=1, count_out==1: done=1 for exactly that next cycle; next count per CONFIGURATION.
//  - EXPIRED: count_out=0 held, count_enable ignored; leave only via load, clear, rst.
//  - terminal_flag computed from next-state values so it is valid in the same cycle count_out==1.
//  - No wrap below 0: decrement never occurs from 0. Unsigned arithmetic, NUM_CNT_BITS wide.
//  - Latency: load/enable sampled at edge k -> outputs updated after edge k (1 cycle).
// CONFIGURATION
//  AUTO_RELOAD_EN defined: on enabled decrement from 1, count_out<=reload_reg, state stays RUN, done
//    pulses; period = reload_reg enabled cycles; EXPIRED reachable only via load_val==0.
//  AUTO_RELOAD_EN undefined: on enabled decrement from 1, count_out<=0, state<=EXPIRED, done pulses.
// STRUCTURE
//  - flex_timer_pkg: typedef enum logic [1:0] {IDLE, RUN, EXPIRED} timer_state_t; shared by timers.
//  - One sub-module: flex_timer_fsm (state register + next-state logic, outputs busy/expired and a
//    dec/reload/zero select); datapath count/reload registers and flags stay in the top module.
//  - All state in a single always_ff on clk with synchronous rst; next-state in always_comb.
// TESTING (NUM_CNT_BITS=4, checks just before the next rising edge)
//  1 rst=1 for 2 cycles mid-count -> count_out=0, terminal_flag=done=busy=expired=0.
//  2 load_val=3 load 1 cycle, enable=1 -> count 3,2,1 (terminal_flag=1 at 1), then done=1 for 1 cycle;
//    no macro: count 0, expired=1; AUTO_RELOAD_EN: count 3, busy=1, second done after 3 more cycles.
//  3 load_val=7, enable 3 cycles, enable=0 for 2 cycles -> count_out holds 4, no done.
//  4 clear=load=count_enable=1 same edge at count 5 -> count_out=0, state IDLE, done=0.
//  5 RUN at count 5, load_val=9 load -> count_out=9 next edge, done=0; load_val=0 -> expired=1, done=0.
//  6 load_val=15 (max), enable continuous -> 15..1 in 15 cycles, done once, never wraps to 15 w/o macro.

Source files
------------

// File: rtl/flex_timer_pkg.sv
// Shared state and count-select encodings for the flex timer family.
// AUTO_RELOAD_EN (optional) is consumed by the FSM and top, not by this package.
package flex_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  // SEL_TERM marks the enabled step out of count 1; the top decides reload vs. zero.
  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_LOAD = 3'd1,
    SEL_DEC  = 3'd2,
    SEL_TERM = 3'd3,
    SEL_ZERO = 3'd4
  } cnt_sel_t;

endpackage

// File: rtl/flex_timer_fsm.sv
// Control FSM for the countdown timer: state register, next-state and count select.
// Macro AUTO_RELOAD_EN: the terminal step stays in RUN instead of going to EXPIRED.
module flex_timer_fsm
  import flex_timer_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         load_zero_i,
  input  logic         count_enable_i,
  input  logic         cnt_is_one_i,
  input  logic         cnt_is_zero_i,
  output timer_state_t state_d_o,
  output cnt_sel_t     sel_o,
  output logic         busy_o,
  output logic         expired_o
);

  timer_state_t state_q, state_d;
  cnt_sel_t     sel;

  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    if (clear_i) begin
      state_d = IDLE;
      sel     = SEL_ZERO;
    end else if (load_i) begin
      state_d = load_zero_i ? EXPIRED : RUN;
      sel     = SEL_LOAD;
    end else begin
      case (state_q)
        RUN: begin
          if (count_enable_i) begin
            if (cnt_is_one_i) begin
              sel = SEL_TERM;
`ifdef AUTO_RELOAD_EN
              state_d = RUN;
`else
              state_d = EXPIRED;
`endif
            end else if (!cnt_is_zero_i) begin
              sel = SEL_DEC;
            end
          end
        end
        EXPIRED: sel = SEL_ZERO;
        default: sel = SEL_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign state_d_o = state_d;
  assign sel_o     = sel;
  assign busy_o    = (state_q == RUN);
  assign expired_o = (state_q == EXPIRED);

endmodule

// File: rtl/flex_countdown_timer.sv
// Loadable down-counter with terminal flag and one-cycle done pulse on expiry.
// Macro AUTO_RELOAD_EN: terminal step reloads the captured start value and keeps running.
module flex_countdown_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    terminal_flag,
  output logic                    done,
  output logic                    busy,
  output logic                    expired
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
  logic                    term_q, term_d;
  logic                    done_q, done_d;
  timer_state_t            state_d;
  cnt_sel_t                sel;

  flex_timer_fsm u_fsm (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .load_i         (load),
    .load_zero_i    (load_val == '0),
    .count_enable_i (count_enable),
    .cnt_is_one_i   (count_q == CNT_ONE),
    .cnt_is_zero_i  (count_q == '0),
    .state_d_o      (state_d),
    .sel_o          (sel),
    .busy_o         (busy),
    .expired_o      (expired)
  );

  always_comb begin
    case (sel)
      SEL_LOAD: count_d = load_val;
      SEL_DEC:  count_d = count_q - CNT_ONE;
`ifdef AUTO_RELOAD_EN
      SEL_TERM: count_d = reload_q;
`else
      SEL_TERM: count_d = '0;
`endif
      SEL_ZERO: count_d = '0;
      default:  count_d = count_q;
    endcase
    reload_d = (sel == SEL_LOAD) ? load_val : reload_q;
    // Flag follows next-state values so it is aligned with count_out==1.
    term_d   = (state_d == RUN) && (count_d == CNT_ONE);
    done_d   = (sel == SEL_TERM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
      term_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      term_q   <= term_d;
      done_q   <= done_d;
    end
  end

  assign count_out     = count_q;
  assign terminal_flag = term_q;
  assign done          = done_q;

endmodule

// File: tb/tb_flex_countdown_timer.sv
// Scoreboard bench for flex_countdown_timer (NUM_CNT_BITS=4); honours AUTO_RELOAD_EN if defined.
module tb_flex_countdown_timer;

  logic       clk = 1'b0;
  logic       rst, clear, load, count_enable;
  logic [3:0] load_val;
  logic [3:0] count_out;
  logic       terminal_flag, done, busy, expired;

  typedef struct {
    logic [3:0] cnt;
    logic       term;
    logic       done;
    logic       busy;
    logic       expd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state: 0 idle, 1 run, 2 expired
  logic [3:0] m_cnt = 4'd0;
  logic [3:0] m_rel = 4'd0;
  int         m_st  = 0;
  logic       m_done = 1'b0;

  flex_countdown_timer #(.NUM_CNT_BITS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .load          (load),
    .load_val      (load_val),
    .count_enable  (count_enable),
    .count_out     (count_out),
    .terminal_flag (terminal_flag),
    .done          (done),
    .busy          (busy),
    .expired       (expired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic l,
                            input logic [3:0] v, input logic e);
    m_done = 1'b0;
    if (r) begin
      m_cnt = 0; m_rel = 0; m_st = 0;
    end else if (c) begin
      m_cnt = 0; m_st = 0;
    end else if (l) begin
      m_rel = v; m_cnt = v;
      m_st  = (v != 0) ? 1 : 2;
    end else if (m_st == 1 && e) begin
      if (m_cnt == 1) begin
        m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
        m_cnt = m_rel;
`else
        m_cnt = 0;
        m_st  = 2;
`endif
      end else begin
        m_cnt = m_cnt - 4'd1;
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic l,
                      input logic [3:0] v, input logic e);
    exp_t x;
    exp_t got;
    rst = r; clear = c; load = l; load_val = v; count_enable = e;
    model_step(r, c, l, v, e);
    x.cnt  = m_cnt;
    x.term = (m_st == 1) && (m_cnt == 4'd1);
    x.done = m_done;
    x.busy = (m_st == 1);
    x.expd = (m_st == 2);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      check_eq("count_out", int'(count_out), int'(got.cnt));
      check_eq("terminal_flag", int'(terminal_flag), int'(got.term));
      check_eq("done", int'(done), int'(got.done));
      check_eq("busy", int'(busy), int'(got.busy));
      check_eq("expired", int'(expired), int'(got.expd));
    end
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0; count_enable = 1'b0;

    // 1: reset mid-count
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 4'd7, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check_eq("t1_count_zero", int'(count_out), 0);

    // 2: load 3, run through expiry (or reload)
    step(0, 0, 1, 4'd3, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

    // 3: discontinuous counting holds
    step(0, 0, 1, 4'd7, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    check_eq("t3_hold4", int'(count_out), 4);

    // 4: clear wins over load and enable
    step(0, 0, 1, 4'd5, 0);
    step(0, 1, 1, 4'd9, 1);
    check_eq("t4_clear_cnt", int'(count_out), 0);
    check_eq("t4_clear_busy", int'(busy), 0);
    step(0, 0, 0, 0, 1);

    // 5: reload mid-run, then load zero
    step(0, 0, 1, 4'd5, 0);
    step(0, 0, 1, 4'd9, 1);
    check_eq("t5_reload9", int'(count_out), 9);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 4'd0, 1);
    check_eq("t5_expired", int'(expired), 1);
    check_eq("t5_no_done", int'(done), 0);
    step(0, 0, 0, 0, 1);

    // 6: max load, continuous enable, exactly one done in 15 cycles
    step(0, 0, 1, 4'd15, 0);
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 0, 1);
      if (done) done_cnt++;
    end
    check_eq("t6_done_once", done_cnt, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

    // randomised mix
    for (int i = 0; i < 120; i++) begin
      int unsigned rr;
      rr = $urandom_range(0, 99);
      step(rr < 2, (rr >= 2 && rr < 6), (rr >= 6 && rr < 16),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
